prbs_pattern_checker: RTL and testbench

//  Receive-side counterpart of the PRBS repetitive-pattern generator. Takes the byte stream
//  (pattern + Pattern_check qualifier), rebuilds the 32-bit words LSB-byte-first, compares each

---
 rtl/prbs_pkg.sv | 14 +
 rtl/prbs_sat_counter.sv | 21 ++
 rtl/prbs_pattern_checker.sv | 119 +++++++++++
 tb/tb_prbs_pattern_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS repetitive-pattern generator and checker.
package prbs_pkg;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int OUTPUT_WIDTH_DEF = 8;
  localparam int REP_WIDTH_DEF    = 8;
  localparam int ERR_WIDTH_DEF    = 16;
  localparam int BYTES_PER_WORD   = DATA_WIDTH_DEF / OUTPUT_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } prbs_state_e;
endpackage

// File: rtl/prbs_sat_counter.sv
// Width-parameterised counter with synchronous clear and saturating increment.
module prbs_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  // Clear has priority; increment stops at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_cnt <= '0;
    else if (i_clr)                            r_cnt <= '0;
    else if (i_inc && (r_cnt != {WIDTH{1'b1}})) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/prbs_pattern_checker.sv
// Sink-side PRBS checker: rebuilds reference words LSB-byte-first, compares each
// qualified byte, counts N words and reports done/pass with a saturating error count.
module prbs_pattern_checker
  import prbs_pkg::*;
#(
  parameter int data_width       = DATA_WIDTH_DEF,
  parameter int Repetitive_width = REP_WIDTH_DEF,
  parameter int output_width     = OUTPUT_WIDTH_DEF,
  parameter int ERR_WIDTH        = ERR_WIDTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [data_width-1:0]       IN,
  input  logic [Repetitive_width-1:0] N,
  input  logic                        valid,
  input  logic [output_width-1:0]     pattern,
  input  logic                        Pattern_check,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        byte_err,
  output logic [ERR_WIDTH-1:0]        err_count,
  output logic [Repetitive_width-1:0] word_count
);
  localparam int BYTES = data_width / output_width;
  localparam int K_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(BYTES - 1);

  prbs_state_e                 r_state;
  logic [data_width-1:0]       r_ref;
  logic [Repetitive_width-1:0] r_n;
  logic [K_W-1:0]              r_k;
  logic [Repetitive_width-1:0] r_word_count;
  logic                        r_busy, r_done, r_pass, r_byte_err;

  logic [output_width-1:0]     w_exp;
  logic                        w_start, w_chk, w_mismatch;
  logic [Repetitive_width-1:0] w_wc_next;
  logic [ERR_WIDTH-1:0]        w_err_cnt;

  assign w_exp      = r_ref[r_k*output_width +: output_width];
  // valid only restarts from IDLE/DONE; in CHECK it is ignored.
  assign w_start    = valid && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_chk      = (r_state == ST_CHECK) && Pattern_check;
  assign w_mismatch = w_chk && (pattern != w_exp);
  assign w_wc_next  = r_word_count + 1'b1;

  prbs_sat_counter #(.WIDTH(ERR_WIDTH)) u_err_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (w_start),
    .i_inc   (w_mismatch),
    .o_cnt   (w_err_cnt)
  );

  // Control FSM plus byte/word tracking; status flags are updated on state transitions.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_ref        <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_byte_err <= w_mismatch;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (valid) begin
            r_ref        <= IN;
            r_n          <= N;
            r_k          <= '0;
            r_word_count <= '0;
            if (N == '0) begin
              // Nothing to check: report an immediate clean pass.
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_CHECK;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (Pattern_check) begin
            if (r_k == K_LAST) begin
              r_k          <= '0;
              r_word_count <= w_wc_next;
              if (w_wc_next == r_n) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                // Final byte's mismatch is not yet in the counter, so fold it in here.
                r_pass  <= (w_err_cnt == '0) && !w_mismatch;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign byte_err   = r_byte_err;
  assign err_count  = w_err_cnt;
  assign word_count = r_word_count;
endmodule

// File: tb/tb_prbs_pattern_checker.sv
// Scoreboard bench for prbs_pattern_checker: stimulus queues expected end-of-run
// results and byte_err cycles; monitors pop and compare when the DUT presents them.
module tb_prbs_pattern_checker;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IN;
  logic [7:0]  N;
  logic        valid, valid2;
  logic [7:0]  pattern;
  logic        Pattern_check;

  logic        busy, done, pass, byte_err;
  logic [15:0] err_count;
  logic [7:0]  word_count;
  logic        busy2, done2, pass2, byte_err2;
  logic [1:0]  err_count2;
  logic [7:0]  word_count2;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [15:0] err;
    logic [7:0]  wc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   berr_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   berr2_cnt = 0;
  logic done_prev = 1'b0;
  logic done2_prev = 1'b0;

  prbs_pattern_checker dut (
    .CLK(CLK), .RST(RST), .IN(IN), .N(N), .valid(valid), .pattern(pattern),
    .Pattern_check(Pattern_check), .busy(busy), .done(done), .pass(pass),
    .byte_err(byte_err), .err_count(err_count), .word_count(word_count)
  );

  prbs_pattern_checker #(.ERR_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .IN(IN), .N(N), .valid(valid2), .pattern(pattern),
    .Pattern_check(Pattern_check), .busy(busy2), .done(done2), .pass(pass2),
    .byte_err(byte_err2), .err_count(err_count2), .word_count(word_count2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main-instance monitor: byte_err strobes and end-of-run results.
  always @(negedge CLK) begin
    if (byte_err) begin
      if (berr_q.size() == 0) chk("byte_err unexpected", 1, 0);
      else begin
        chk("byte_err cycle", cyc, berr_q[0]);
        void'(berr_q.pop_front());
      end
    end
    if (done && !done_prev) begin
      if (exp_q.size() == 0) chk("done unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done cycle", cyc, e.cyc);
        chk("pass", pass, e.pass);
        chk("err_count", err_count, e.err);
        chk("word_count", word_count, e.wc);
        chk("busy at done", busy, 0);
      end
    end
    done_prev = done;
  end

  // Narrow-counter instance monitor.
  always @(negedge CLK) begin
    if (byte_err2) berr2_cnt++;
    if (done2 && !done2_prev) begin
      if (exp2_q.size() == 0) chk("done2 unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp2_q.pop_front();
        chk("sat pass", pass2, e.pass);
        chk("sat err_count", err_count2, e.err);
        chk("sat word_count", word_count2, e.wc);
        chk("sat byte_err strobes", berr2_cnt, 8);
      end
    end
    done2_prev = done2;
  end

  task automatic send(input logic [7:0] b);
    Pattern_check = 1'b1;
    pattern = b;
    @(posedge CLK); #1;
    Pattern_check = 1'b0;
  endtask

  task automatic start(input logic [31:0] w, input logic [7:0] n);
    exp_t e;
    IN = w; N = n; valid = 1'b1;
    if (n == 0) begin
      e.cyc = cyc + 1; e.pass = 1'b1; e.err = 16'h0; e.wc = 8'h0;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] w, input logic [7:0] n, input int bad_idx,
                     input int gap_at, input logic e_pass, input logic [15:0] e_err,
                     input logic [7:0] e_wc);
    exp_t e;
    logic [7:0] b;
    start(w, n);
    for (int i = 0; i < int'(n) * 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          // Mid-run start attempt with a different word and N=0 must be ignored.
          if (g == 1) begin valid = 1'b1; IN = 32'h0; N = 8'h0; end
          @(posedge CLK); #1;
          valid = 1'b0;
        end
      end
      b = w[(i % 4) * 8 +: 8];
      if (i == bad_idx) begin
        b = b ^ 8'h01;
        berr_q.push_back(cyc + 1);
      end
      if (i == int'(n) * 4 - 1) begin
        e.cyc = cyc + 1; e.pass = e_pass; e.err = e_err; e.wc = e_wc;
        exp_q.push_back(e);
      end
      send(b);
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    RST = 1'b0; IN = '0; N = '0; valid = 1'b0; valid2 = 1'b0;
    pattern = '0; Pattern_check = 1'b0;
    #3;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset byte_err", byte_err, 0);
    chk("reset err_count", err_count, 0);
    chk("reset word_count", word_count, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // N=0: immediate done/pass, busy never high.
    start(32'h1234_5678, 8'd0);
    chk("n0 busy", busy, 0);
    repeat (2) @(posedge CLK);
    #1;

    // Clean two-word run.
    run(32'hA1B2_C3D4, 8'd2, -1, -1, 1'b1, 16'd0, 8'd2);
    // Third byte corrupted (B2 -> B3).
    run(32'hA1B2_C3D4, 8'd2, 2, -1, 1'b0, 16'd1, 8'd2);
    // Gap of 3 cycles between bytes 2 and 3, with a valid pulse inside it.
    run(32'hA1B2_C3D4, 8'd2, -1, 2, 1'b1, 16'd0, 8'd2);

    // Saturating 2-bit error counter: 8 mismatches clamp at 3.
    IN = 32'h0; N = 8'd2; valid2 = 1'b1;
    e.cyc = 0; e.pass = 1'b0; e.err = 16'd3; e.wc = 8'd2;
    exp2_q.push_back(e);
    @(posedge CLK); #1;
    valid2 = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hFF);
    repeat (2) @(posedge CLK);
    #1;

    // Asynchronous reset mid-run, then a fresh clean run.
    start(32'hA1B2_C3D4, 8'd2);
    send(8'hD4); send(8'hC3); send(8'hB2);
    RST = 1'b0;
    #2;
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    chk("async pass", pass, 0);
    chk("async byte_err", byte_err, 0);
    chk("async err_count", err_count, 0);
    chk("async word_count", word_count, 0);
    @(posedge CLK); #1;
    chk("held reset busy", busy, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    run(32'hA1B2_C3D4, 8'd2, -1, -1, 1'b1, 16'd0, 8'd2);

    repeat (3) @(posedge CLK);
    #1;
    chk("pending done results", exp_q.size(), 0);
    chk("pending sat results", exp2_q.size(), 0);
    chk("pending byte_err strobes", berr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
